// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared colour type and default 640x480 timing for the VGA sync block
package vga_pkg;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    localparam int CNT_W        = 11;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth register pipeline with async reset to a parameterised value
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_sync_out.sv
// rtl/vga_sync_out.sv - VGA timing counters, sync generation and blanked colour output; VGA_BORDER_EN adds a white frame border
module vga_sync_out
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter int PIPE_DLY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      rgb_in,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             active,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
`ifdef VGA_BORDER_EN
    localparam logic [CNT_W-1:0] H_EDGE = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_EDGE = CNT_W'(V_ACTIVE - 1);
    localparam int PW = 1 + 2 * CNT_W;
`else
    localparam int PW = 1;
`endif

    logic          run;
    logic          hs_raw;
    logic          vs_raw;
    logic          act_d;
    logic [1:0]    syncs;
    logic [PW-1:0] pre_in;
    logic [PW-1:0] pre_out;
    rgb12_t        pix;

    // The first cycle after reset only arms the counters, so hc=vc=0 is issued
    // (with frame_start) on the cycle following the first clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (run) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    assign active      = run && (hc < H_VIS) && (vc < V_VIS);
    assign frame_start = run && (hc == '0) && (vc == '0);
    assign hs_raw      = !((hc >= HS_BEG) && (hc < HS_END));
    assign vs_raw      = !((vc >= VS_BEG) && (vc < VS_END));

    vga_delay_line #(
        .WIDTH  (2),
        .DEPTH  (PIPE_DLY + 1),
        .RST_VAL(2'b11)
    ) u_sync_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({hs_raw, vs_raw}),
        .dout (syncs)
    );

    assign vga_hs = syncs[1];
    assign vga_vs = syncs[0];

    // Blanking (and border coordinates) are delayed to meet rgb_in; the colour
    // register below is the final stage that lines them up with the syncs.
    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign pre_out = pre_in;
        end else begin : g_dly
            vga_delay_line #(
                .WIDTH  (PW),
                .DEPTH  (PIPE_DLY),
                .RST_VAL('0)
            ) u_pre_dly (
                .clk  (clk),
                .rst_n(rst_n),
                .din  (pre_in),
                .dout (pre_out)
            );
        end
    endgenerate

    assign act_d = pre_out[PW-1];

`ifdef VGA_BORDER_EN
    logic [CNT_W-1:0] hc_d;
    logic [CNT_W-1:0] vc_d;
    logic             edge_px;

    assign pre_in  = {active, hc, vc};
    assign hc_d    = pre_out[2*CNT_W-1:CNT_W];
    assign vc_d    = pre_out[CNT_W-1:0];
    assign edge_px = (hc_d == '0) || (hc_d == H_EDGE) || (vc_d == '0) || (vc_d == V_EDGE);
`else
    assign pre_in = active;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pix <= '0;
        else if (!act_d)
            pix <= '0;
`ifdef VGA_BORDER_EN
        else if (edge_px)
            pix <= rgb12_t'(12'hFFF);
`endif
        else
            pix <= rgb12_t'(rgb_in);
    end

    assign vga_r = pix.r;
    assign vga_g = pix.g;
    assign vga_b = pix.b;

endmodule

// File: tb/tb_vga_sync_out.sv
// tb/tb_vga_sync_out.sv - self-checking bench for vga_sync_out against a frame-index model
module tb_vga_sync_out;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] rgb3  = 12'h000;

    logic [10:0] hc0, vc0, hc3, vc3, hcz, vcz;
    logic        act0, act3, actz, fs0, fs3, fsz;
    logic        hs0, hs3, hsz, vs0, vs3, vsz;
    logic [3:0]  r0, g0, b0, r3, g3, b3, rz, gz, bz;

    int k = -1;
    int vectors = 0;
    int miscompares = 0;
    int rx, ry;

    always #5 clk = ~clk;

    vga_sync_out #(.PIPE_DLY(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .rgb_in(12'hA5C), .hc(hc0), .vc(vc0), .active(act0),
        .vga_r(r0), .vga_g(g0), .vga_b(b0), .vga_hs(hs0), .vga_vs(vs0), .frame_start(fs0));

    vga_sync_out #(.PIPE_DLY(3)) u_d3 (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb3), .hc(hc3), .vc(vc3), .active(act3),
        .vga_r(r3), .vga_g(g3), .vga_b(b3), .vga_hs(hs3), .vga_vs(vs3), .frame_start(fs3));

    vga_sync_out #(.PIPE_DLY(0)) u_dz (
        .clk(clk), .rst_n(rst_n), .rgb_in(12'h000), .hc(hcz), .vc(vcz), .active(actz),
        .vga_r(rz), .vga_g(gz), .vga_b(bz), .vga_hs(hsz), .vga_vs(vsz), .frame_start(fsz));

    // k = cycles since the frame_start cycle that followed the last reset release (-1 in reset)
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= -1;
        else        k <= k + 1;
    end

    function automatic int xof(input int n);
        return n % 800;
    endfunction

    function automatic int yof(input int n);
        return (n / 800) % 525;
    endfunction

    // {hc, vc, active, frame_start, rgb, hs, vs} expected while issue index kk is current
    function automatic logic [37:0] model(input int kk, input int d, input int mode);
        int x, y, s, sx, sy;
        logic [10:0] ehc = '0, evc = '0;
        logic        eact = 1'b0, efs = 1'b0, ehs = 1'b1, evs = 1'b1;
        logic [11:0] ergb = 12'h000;
        if (kk >= 0) begin
            x    = xof(kk);
            y    = yof(kk);
            ehc  = x[10:0];
            evc  = y[10:0];
            eact = (x < 640) && (y < 480);
            efs  = (kk % 420000) == 0;
        end
        s = kk - (d + 1);
        if (kk >= 0 && s >= 0) begin
            sx  = xof(s);
            sy  = yof(s);
            ehs = !(sx >= 656 && sx < 752);
            evs = !(sy >= 490 && sy < 492);
            if (sx < 640 && sy < 480) begin
                case (mode)
                    0:       ergb = 12'hA5C;
                    1:       ergb = {sx[3:0], sy[3:0], 4'h0};
                    default: ergb = 12'h000;
                endcase
`ifdef VGA_BORDER_EN
                if (sx == 0 || sx == 639 || sy == 0 || sy == 479) ergb = 12'hFFF;
`endif
            end
        end
        return {ehc, evc, eact, efs, ergb, ehs, evs};
    endfunction

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s (k=%0d): got %h, expected %h", nm, k, act, exp);
        end
    endtask

    // rgb for the PIPE_DLY=3 instance follows the coordinates issued three cycles earlier
    always @(negedge clk) begin
        if (k >= 3) begin
            rx   = xof(k - 3);
            ry   = yof(k - 3);
            rgb3 = {rx[3:0], ry[3:0], 4'h0};
        end else begin
            rgb3 = 12'h000;
        end
    end

    always @(negedge clk) begin
        cmp("d0_cycle", {hc0, vc0, act0, fs0, r0, g0, b0, hs0, vs0}, model(k, 0, 0));
        cmp("d3_cycle", {hc3, vc3, act3, fs3, r3, g3, b3, hs3, vs3}, model(k, 3, 1));
        cmp("dz_cycle", {hcz, vcz, actz, fsz, rz, gz, bz, hsz, vsz}, model(k, 0, 2));
    end

    initial begin
        logic [37:0] m;
        int fs_at, nz0, nzz, max_h, max_v, target;

        m = model(0, 0, 0);      cmp("model_origin", m, {11'd0, 11'd0, 1'b1, 1'b1, 12'h000, 1'b1, 1'b1});
        m = model(656, 0, 0);    cmp("model_hs_656", m[1], 1'b1);
        m = model(657, 0, 0);    cmp("model_hs_657", m[1], 1'b0);
        m = model(752, 0, 0);    cmp("model_hs_752", m[1], 1'b0);
        m = model(753, 0, 0);    cmp("model_hs_753", m[1], 1'b1);
        m = model(392000, 0, 0); cmp("model_vs_489", m[0], 1'b1);
        m = model(392001, 0, 0); cmp("model_vs_490", m[0], 1'b0);
        m = model(393600, 0, 0); cmp("model_vs_491", m[0], 1'b0);
        m = model(393601, 0, 0); cmp("model_vs_492", m[0], 1'b1);
        m = model(802, 0, 0);    cmp("model_rgb_vis", m[13:2], 12'hA5C);
        m = model(1441, 0, 0);   cmp("model_rgb_blank", m[13:2], 12'h000);
        m = model(805, 3, 1);    cmp("model_rgb_d3", m[13:2], 12'h110);
        m = model(419999, 0, 0); cmp("model_last", m[37:16], {11'd799, 11'd524});
        m = model(420000, 0, 0); cmp("model_wrap", {m[37:16], m[14]}, {22'd0, 1'b1});

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp("reset_state", {hc0, vc0, act0, fs0, r0, g0, b0, hs0, vs0},
            {11'd0, 11'd0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1});
        rst_n = 1'b1;
        @(negedge clk);
        cmp("fs_after_release", {fs0, hc0, vc0}, {1'b1, 22'd0});

        fs_at = -1; nz0 = 0; nzz = 0; max_h = 0; max_v = 0;
        for (int i = 1; i <= 420000; i++) begin
            @(negedge clk);
            if (fs0 && fs_at < 0) fs_at = i;
            if ({r0, g0, b0} != 12'h000) nz0++;
            if ({rz, gz, bz} != 12'h000) nzz++;
            if (int'(hc0) > max_h) max_h = int'(hc0);
            if (int'(vc0) > max_v) max_v = int'(vc0);
        end
        cmp("fs_period", fs_at, 420000);
        cmp("max_hc", max_h, 799);
        cmp("max_vc", max_v, 524);
        cmp("visible_pixels", nz0, 307200);
`ifdef VGA_BORDER_EN
        cmp("border_pixels", nzz, 2236);
`else
        cmp("border_pixels", nzz, 0);
`endif

        target = 420000 + 200 * 800 + 300;
        for (int i = 0; i < 200000 && k != target; i++) @(negedge clk);
        cmp("pre_reset_coord", {hc0, vc0}, {11'd300, 11'd200});
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async_reset_d0", {hc0, vc0, act0, fs0, r0, g0, b0, hs0, vs0},
            {11'd0, 11'd0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1});
        cmp("async_reset_d3", {hc3, vc3, act3, fs3, r3, g3, b3, hs3, vs3},
            {11'd0, 11'd0, 1'b0, 1'b0, 12'h000, 1'b1, 1'b1});
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cmp("fs_after_rerelease", {fs0, fs3, hc0, vc0}, {2'b11, 22'd0});
        repeat (2000) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
